// File: rtl/mul_div_if.sv
// Handshake bundle for the iterative multiply/divide unit.
// master drives requests, slave returns results.
interface mul_div_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        cancel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, in1, in2, cancel,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, in1, in2, cancel,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Radix-2 shift-add multiplier / restoring divider, fixed 34-cycle latency.
// Define MULDIV_SIGNED_EN to make MUL/DIV signed; otherwise they act as MULU/DIVU.
module mul_div_unit (
  input  logic      clk,
  input  logic      rst,
  mul_div_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] b_q;
  logic [31:0] in1_q;
  logic        is_div_q;
  logic        neg_q;
  logic        neg_r;
  logic        dz_q;

  logic        signed_op;
  logic        is_div;
  logic [31:0] in1_mag;
  logic [31:0] in2_mag;

`ifdef MULDIV_SIGNED_EN
  assign signed_op = ~bus.op[0];
`else
  assign signed_op = 1'b0;
`endif

  assign is_div  = bus.op[1];
  assign in1_mag = (signed_op & bus.in1[31]) ? (32'd0 - bus.in1) : bus.in1;
  assign in2_mag = (signed_op & bus.in2[31]) ? (32'd0 - bus.in2) : bus.in2;

  logic [32:0] mul_sum;
  logic [63:0] mul_nx;
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [63:0] div_nx;

  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_q} : 33'd0);
  assign mul_nx  = {mul_sum, acc[31:1]};

  // Remainder in acc[63:32], dividend/quotient shifts through acc[31:0].
  assign div_sh   = {acc[63:32], acc[31]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_nx   = div_diff[32]
                  ? {div_sh[31:0], acc[30:0], 1'b0}
                  : {div_diff[31:0], acc[30:0], 1'b1};

  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] p_fix;
  logic [63:0] fix_nx;

  assign q_fix = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
  assign r_fix = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];
  assign p_fix = neg_q ? (64'd0 - acc) : acc;

  always_comb begin
    fix_nx = p_fix;
    unique case (1'b1)
      is_div_q & dz_q:  fix_nx = {in1_q, 32'hFFFF_FFFF};
      is_div_q & ~dz_q: fix_nx = {r_fix, q_fix};
      default:          fix_nx = p_fix;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      acc          <= 64'd0;
      b_q          <= 32'd0;
      in1_q        <= 32'd0;
      is_div_q     <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz_q         <= 1'b0;
      bus.hi       <= 32'd0;
      bus.lo       <= 32'd0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (bus.cancel) begin
        state    <= IDLE;
        cnt      <= 5'd0;
        bus.busy <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state    <= CALC;
              cnt      <= 5'd0;
              bus.busy <= 1'b1;
              in1_q    <= bus.in1;
              is_div_q <= is_div;
              neg_q    <= signed_op & (bus.in1[31] ^ bus.in2[31]);
              neg_r    <= signed_op & bus.in1[31];
              dz_q     <= is_div & (bus.in2 == 32'd0);
              acc      <= {32'd0, is_div ? in1_mag : in2_mag};
              b_q      <= is_div ? in2_mag : in1_mag;
            end
          end
          CALC: begin
            acc <= is_div_q ? div_nx : mul_nx;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31)
              state <= FIX;
          end
          FIX: begin
            acc      <= fix_nx;
            state    <= DONE;
            bus.busy <= 1'b0;
          end
          DONE: begin
            // Results only reach hi/lo here, so a late cancel leaves them intact.
            bus.hi       <= acc[63:32];
            bus.lo       <= acc[31:0];
            bus.div_zero <= dz_q;
            bus.done     <= 1'b1;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, decoupled monitor.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  mul_div_if bus ();

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          t0;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

`ifdef MULDIV_SIGNED_EN
  localparam logic [31:0] M37_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] M45_HI = 32'h0000_0000;
  localparam logic [31:0] D72_LO = 32'hFFFF_FFFD;
  localparam logic [31:0] D72_HI = 32'hFFFF_FFFF;
  localparam logic [31:0] D7N_LO = 32'hFFFF_FFFD;
  localparam logic [31:0] D7N_HI = 32'h0000_0001;
  localparam logic [31:0] DMN_LO = 32'h8000_0000;
  localparam logic [31:0] DMN_HI = 32'h0000_0000;
`else
  localparam logic [31:0] M37_HI = 32'h0000_0006;
  localparam logic [31:0] M45_HI = 32'hFFFF_FFF7;
  localparam logic [31:0] D72_LO = 32'h7FFF_FFFC;
  localparam logic [31:0] D72_HI = 32'h0000_0001;
  localparam logic [31:0] D7N_LO = 32'h0000_0000;
  localparam logic [31:0] D7N_HI = 32'h0000_0007;
  localparam logic [31:0] DMN_LO = 32'h0000_0000;
  localparam logic [31:0] DMN_HI = 32'h8000_0000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi", bus.hi, e.hi);
        chk("lo", bus.lo, e.lo);
        chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
        chk("latency", cyc - e.t0, 32'd34);
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic push,
                       input logic [31:0] eh, input logic [31:0] el,
                       input logic edz);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = o;
    bus.in1   = a;
    bus.in2   = b;
    if (push) begin
      e.hi = eh;
      e.lo = el;
      e.dz = edz;
      e.t0 = cyc + 1;
      sb.push_back(e);
      last_hi = eh;
      last_lo = el;
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 45 && sb.size() != 0; i++)
      @(negedge clk);
    chk("drain_pending", sb.size(), 32'd0);
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh,
                     input logic [31:0] el, input logic edz);
    issue(o, a, b, 1'b1, eh, el, edz);
    drain();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_hi"}, bus.hi, 32'd0);
    chk({tag, "_lo"}, bus.lo, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_dz"}, {31'd0, bus.div_zero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    last_hi    = 32'd0;
    last_lo    = 32'd0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 2'b00;
    bus.in1    = 32'd0;
    bus.in2    = 32'd0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    run(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run(OP_MUL, 32'hFFFF_FFFD, 32'd7, M37_HI, 32'hFFFF_FFEB, 1'b0);
    run(OP_MUL, 32'hFFFF_FFFC, 32'hFFFF_FFFB, M45_HI, 32'h0000_0014, 1'b0);
    run(OP_DIV, 32'hFFFF_FFF9, 32'd2, D72_HI, D72_LO, 1'b0);
    run(OP_DIV, 32'd7, 32'hFFFF_FFFE, D7N_HI, D7N_LO, 1'b0);
    run(OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1);
    run(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    run(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DMN_HI, DMN_LO, 1'b0);
    run(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

    // start while busy is ignored; hi/lo hold the previous result mid-op
    issue(OP_MULU, 32'd5, 32'd6, 1'b1, 32'd0, 32'd30, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_mid", {31'd0, bus.busy}, 32'd1);
    chk("hold_hi_mid", bus.hi, 32'd2);
    chk("hold_lo_mid", bus.lo, 32'd14);
    issue(OP_DIVU, 32'd100, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0);
    drain();

    // cancel at cycle 10, restart at cycle 12
    issue(OP_MULU, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (8) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_hold_lo", bus.lo, 32'd30);
    @(negedge clk);
    issue(OP_MULU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0);
    drain();

    // cancel and start together in IDLE: nothing starts
    bus.cancel = 1'b1;
    issue(OP_MULU, 32'd8, 32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    bus.cancel = 1'b0;
    chk("cancel_start_busy", {31'd0, bus.busy}, 32'd0);
    repeat (40) @(negedge clk);
    chk("cancel_start_lo", bus.lo, 32'd12);

    // reset in the middle of a divide
    issue(OP_DIVU, 32'd1000, 32'd10, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (18) @(negedge clk);
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    last_hi = 32'd0;
    last_lo = 32'd0;
    repeat (40) @(negedge clk);
    chk("post_rst_lo", bus.lo, 32'd0);

    run(OP_MULU, 32'd5, 32'd6, 32'd0, 32'd30, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; widths are fixed at 32-bit operands and 64-bit result.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request pulse; SHALL be sampled only in IDLE.
REQ-005 op  in  2  00 MUL (signed), 01 MULU, 10 DIV (signed), 11 DIVU; SHALL be captured with start.
REQ-006 in1, in2  in  32 each  operands (dividend, divisor); SHALL be captured with start.
REQ-007 cancel  in  1  pipeline flush; SHALL abort any operation in progress.
REQ-008 hi, lo  out  32 each  result; MUL/MULU hi:lo = 64-bit product; DIV/DIVU lo = quotient, hi = remainder.
REQ-009 busy  out  1  high in CALC and FIX.
REQ-010 done  out  1  one-cycle pulse when hi/lo become valid.
REQ-011 div_zero  out  1  high together with done when a divide had in2 = 0.

Function
REQ-012 The FSM SHALL use states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after exactly 32 iterations, FIX->DONE, DONE->IDLE.
REQ-013 Multiply SHALL be radix-2 shift-add on operand magnitudes, one bit per CALC cycle.
REQ-014 Divide SHALL be radix-2 restoring on operand magnitudes, one quotient bit per CALC cycle.
REQ-015 Latency SHALL be fixed at 34 cycles from the start-sampling edge to the done edge, for every op and operand value.
REQ-016 FIX SHALL apply sign correction: product negated (64-bit) when operand signs differ; quotient negated when signs differ; remainder takes the dividend's sign.
REQ-017 Signed INT_MIN / -1 SHALL yield lo = 0x80000000, hi = 0x00000000, with no flag.
REQ-018 Divide by zero SHALL still take 34 cycles and yield lo = 0xFFFFFFFF, hi = in1, div_zero = 1.
REQ-019 start while busy or in DONE SHALL be ignored; captured operands SHALL NOT change.
REQ-020 hi/lo SHALL hold their last result from done until the next done; intermediate values SHALL NOT appear on hi/lo.
REQ-021 cancel in any non-IDLE state SHALL force IDLE on the next edge, suppress done, and leave hi/lo unchanged.
REQ-022 cancel and start in the same IDLE cycle SHALL result in cancel winning; no operation starts.
REQ-023 start with op MUL/MULU SHALL clear div_zero on the next done.

Reset
REQ-024 rst SHALL immediately force state = IDLE, hi = 0, lo = 0, busy = 0, done = 0, div_zero = 0, iteration counter = 0.
REQ-025 rst asserted mid-operation SHALL discard the operation; no done SHALL follow reset deassertion.
REQ-026 The first start SHALL be honoured on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro MULDIV_SIGNED_EN: when defined, MUL and DIV SHALL be signed per REQ-016/017.
REQ-028 Without MULDIV_SIGNED_EN, MUL SHALL behave as MULU and DIV as DIVU, and FIX SHALL perform no correction while keeping the 34-cycle latency.

Verification
REQ-029 MULU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 34, hi = 0xFFFFFFFE, lo = 0x00000001.
REQ-030 MUL -3 x 7 (signed enabled) -> hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; without macro -> hi = 0x00000006, lo = 0xFFFFFFEB.
REQ-031 DIV -7 / 2 (signed enabled) -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF; DIVU 7 / 0 -> lo = 0xFFFFFFFF, hi = 7, div_zero = 1.
REQ-032 DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
REQ-033 MULU 5 x 6 started, cancel at cycle 10, second start at cycle 12 -> no done for the first op, previous hi/lo held, second done at cycle 46.
REQ-034 rst pulse at cycle 20 of a divide -> all outputs 0 immediately, no done; start during busy -> ignored, original result unchanged.
